i2c_target_regs: RTL and testbench

- I2C target (responder) for the 7-bit, 100 kHz bus driven by the team's I2C master.
- Exposes a NUM_REGS x 8-bit register file: the bus reads and writes it, and fabric logic can read and update it locally.
- Used as an on-chip MPR121-style stand-in so the touch-polling FSM can be exercised in loopback, and as a generic config/status target.
- SCL is input-only; the block never stretches the clock. SDA is open-drain.

---
 rtl/i2c_target_regs_pkg.sv | 25 ++
 rtl/i2c_line_filter.sv | 44 ++++
 rtl/i2c_target_regs.sv | 209 ++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_regs_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_target_defs;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WR_DATA,
      WR_ACK,
      RD_LOAD,
      RD_DATA,
      RD_ACK,
      IGNORE
   } state_t;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   function automatic int PTR_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus a FILTER_LEN-sample glitch filter with
// single-cycle rise/fall pulses aligned to the filtered level change.
module i2c_line_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CNT_W = $clog2(FILTER_LEN + 1);

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q;

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q <= 2'b11;
         cnt_q  <= '0;
         level  <= 1'b1;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], pin};
         rise   <= 1'b0;
         fall   <= 1'b0;
         if (sync_q[1] == level) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            level <= sync_q[1];
            rise  <= sync_q[1];
            fall  <= ~sync_q[1];
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a NUM_REGS x 8 register file to the bus and to local logic.
// SCL is never stretched; SDA is open-drain via sda_t.
module i2c_target_regs
   import i2c_target_defs::*;
#(
   parameter logic [6:0] ADDRESS    = 7'h5A,
   parameter int         NUM_REGS   = 16,
   parameter int         FILTER_LEN = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       scl_i,
   input  logic                       sda_i,
   output logic                       sda_o,
   output logic                       sda_t,
   input  logic                       host_wr_en,
   input  logic [PTR_W(NUM_REGS)-1:0] host_wr_addr,
   input  logic [7:0]                 host_wr_data,
   input  logic [PTR_W(NUM_REGS)-1:0] host_rd_addr,
   output logic [7:0]                 host_rd_data,
   output logic                       bus_wr_valid,
   output logic [PTR_W(NUM_REGS)-1:0] bus_wr_addr,
   output logic [7:0]                 bus_wr_data,
   output logic                       busy
);

   localparam int AW = PTR_W(NUM_REGS);

   logic scl, scl_rise, scl_fall;
   logic sda, sda_rise, sda_fall;

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
      .clk   (clk),
      .rst   (rst),
      .pin   (scl_i),
      .level (scl),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
      .clk   (clk),
      .rst   (rst),
      .pin   (sda_i),
      .level (sda),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   state_t         state_q, state_d;
   logic [3:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]     shift_q, shift_d;
   logic [AW-1:0]  ptr_q, ptr_d;
   logic           sda_t_q, sda_t_d;
   logic           busy_q, busy_d;
   logic           rw_q, rw_d;
   logic           nack_q, nack_d;
   logic           wr_stb;
   logic [7:0]     regs_q [NUM_REGS];

   logic       start_cond, stop_cond;
   logic [7:0] rx_byte;

   assign start_cond = sda_fall & scl;
   assign stop_cond  = sda_rise & scl;
   assign rx_byte    = {shift_q[6:0], sda};

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      ptr_d     = ptr_q;
      sda_t_d   = sda_t_q;
      busy_d    = busy_q;
      rw_d      = rw_q;
      nack_d    = nack_q;
      wr_stb    = 1'b0;
      if (start_cond) begin
         state_d   = ADDR;
         bit_cnt_d = '0;
         sda_t_d   = 1'b1;
         busy_d    = 1'b1;
      end else if (stop_cond) begin
         state_d = IDLE;
         sda_t_d = 1'b1;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            ADDR, PTR, WR_DATA: begin
               if (scl_rise) begin
                  shift_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d = '0;
                     if (state_q == ADDR) begin
                        if (rx_byte[7:1] == ADDRESS) begin
                           rw_d    = rx_byte[0];
                           state_d = ADDR_ACK;
                        end else begin
                           state_d = IGNORE;
                        end
                     end else if (state_q == PTR) begin
                        ptr_d   = rx_byte[AW-1:0];
                        state_d = PTR_ACK;
                     end else begin
                        wr_stb  = 1'b1;
                        ptr_d   = ptr_q + AW'(1);
                        state_d = WR_ACK;
                     end
                  end
               end
            end
            // First fall after the 8th bit starts driving ACK; the next fall ends it.
            ADDR_ACK, PTR_ACK, WR_ACK: begin
               if (scl_fall) begin
                  if (sda_t_q) begin
                     sda_t_d = ACK;
                  end else begin
                     sda_t_d   = 1'b1;
                     bit_cnt_d = '0;
                     if (state_q == ADDR_ACK) state_d = rw_q ? RD_LOAD : PTR;
                     else                     state_d = WR_DATA;
                  end
               end
            end
            RD_LOAD: begin
               shift_d   = regs_q[ptr_q];
               sda_t_d   = regs_q[ptr_q][7];
               ptr_d     = ptr_q + AW'(1);
               bit_cnt_d = '0;
               state_d   = RD_DATA;
            end
            RD_DATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_t_d = 1'b1;
                     state_d = RD_ACK;
                  end else begin
                     shift_d = {shift_q[6:0], 1'b0};
                     sda_t_d = shift_q[6];
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise)      nack_d  = sda;
               else if (scl_fall) state_d = (nack_q == ACK) ? RD_LOAD : IGNORE;
            end
            IDLE, IGNORE: ;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         ptr_q     <= '0;
         sda_t_q   <= 1'b1;
         busy_q    <= 1'b0;
         rw_q      <= 1'b0;
         nack_q    <= NACK;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         ptr_q     <= ptr_d;
         sda_t_q   <= sda_t_d;
         busy_q    <= busy_d;
         rw_q      <= rw_d;
         nack_q    <= nack_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bus_wr_valid <= 1'b0;
         bus_wr_addr  <= '0;
         bus_wr_data  <= '0;
      end else begin
         bus_wr_valid <= wr_stb;
         if (wr_stb) begin
            bus_wr_addr <= ptr_q;
            bus_wr_data <= rx_byte;
         end
      end
   end

   // NOTE: the register file is cleared by reset because software relies on it reading zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         if (host_wr_en)   regs_q[host_wr_addr] <= host_wr_data;
         // Bus write is issued last so it wins a same-index collision.
         if (bus_wr_valid) regs_q[bus_wr_addr]  <= bus_wr_data;
      end
   end

   assign sda_o        = 1'b0;
   assign sda_t        = sda_t_q;
   assign busy         = busy_q;
   assign host_rd_data = regs_q[host_rd_addr];

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C master, scoreboard of
// expected bus writes and read bytes, immediate-assertion checks.
`timescale 1ns/1ps
module tb_i2c_target_regs;
   import i2c_target_defs::*;

   localparam int Q = 16;

   typedef struct packed {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       scl_m = 1'b1;
   logic       scl_glitch = 1'b0;
   logic       sda_m = 1'b1;
   logic       sda_o, sda_t;
   logic       host_wr_en = 1'b0;
   logic [3:0] host_wr_addr = '0;
   logic [7:0] host_wr_data = '0;
   logic [3:0] host_rd_addr = '0;
   logic [7:0] host_rd_data;
   logic       bus_wr_valid;
   logic [3:0] bus_wr_addr;
   logic [7:0] bus_wr_data;
   logic       busy;
   logic       scl_pin, sda_pin;

   assign scl_pin = scl_m ^ scl_glitch;
   assign sda_pin = sda_m & (sda_t | sda_o);

   i2c_target_regs dut (
      .clk          (clk),
      .rst          (rst),
      .scl_i        (scl_pin),
      .sda_i        (sda_pin),
      .sda_o        (sda_o),
      .sda_t        (sda_t),
      .host_wr_en   (host_wr_en),
      .host_wr_addr (host_wr_addr),
      .host_wr_data (host_wr_data),
      .host_rd_addr (host_rd_addr),
      .host_rd_data (host_rd_data),
      .bus_wr_valid (bus_wr_valid),
      .bus_wr_addr  (bus_wr_addr),
      .bus_wr_data  (bus_wr_data),
      .busy         (busy)
   );

   always #18 clk = ~clk;

   int         tests_run = 0;
   int         tests_failed = 0;
   wr_t        exp_wr_q[$];
   wr_t        obs_wr_q[$];
   int         obs_idx = 0;
   logic [7:0] exp_rd_q[$];
   int         low_cnt = 0;

   always @(negedge clk) begin
      if (rst && bus_wr_valid) obs_wr_q.push_back(wr_t'{bus_wr_addr, bus_wr_data});
      if (!sda_t) low_cnt++;
   end

   initial begin
      #(36 * 95000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic quarter();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; quarter();
      scl_m = 1'b1; quarter();
      sda_m = 1'b0; quarter();
      scl_m = 1'b0; quarter();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; quarter();
      scl_m = 1'b1; quarter();
      sda_m = 1'b1; quarter();
   endtask

   task automatic send_bit(input logic b);
      sda_m = b;    quarter();
      scl_m = 1'b1; quarter(); quarter();
      scl_m = 1'b0; quarter();
   endtask

   task automatic recv_bit(output logic b);
      sda_m = 1'b1; quarter();
      scl_m = 1'b1; quarter();
      b = sda_pin;  quarter();
      scl_m = 1'b0; quarter();
   endtask

   task automatic expect_ack(input logic [7:0] d, input logic exp_ack, input string tag);
      logic a;
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(a);
      check(tag, a, exp_ack);
   endtask

   task automatic drain_writes();
      wr_t e;
      while (obs_idx < obs_wr_q.size()) begin
         check("bus_wr_expected", exp_wr_q.size() > 0, 1'b1);
         if (exp_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front();
            check("bus_wr_addr", obs_wr_q[obs_idx].addr, e.addr);
            check("bus_wr_data", obs_wr_q[obs_idx].data, e.data);
         end
         obs_idx++;
      end
   endtask

   task automatic wr_byte(input logic [3:0] idx, input logic [7:0] d, input string tag);
      exp_wr_q.push_back(wr_t'{idx, d});
      expect_ack(d, ACK, tag);
      drain_writes();
   endtask

   task automatic read_expect(input logic nack, input string tag);
      logic [7:0] d;
      logic       b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         d[i] = b;
      end
      send_bit(nack);
      check(tag, d, exp_rd_q.pop_front());
   endtask

   task automatic host_write(input logic [3:0] idx, input logic [7:0] d);
      host_wr_addr = idx;
      host_wr_data = d;
      host_wr_en   = 1'b1;
      @(negedge clk);
      host_wr_en   = 1'b0;
   endtask

   task automatic check_reg(input logic [3:0] idx, input logic [7:0] exp, input string tag);
      host_rd_addr = idx;
      #1;
      check(tag, host_rd_data, exp);
   endtask

   task automatic open_read(input logic [7:0] ptr, input string tag);
      i2c_start();
      expect_ack(8'hB4, ACK, {tag, "_addr_w"});
      expect_ack(ptr, ACK, {tag, "_ptr"});
      i2c_start();
      expect_ack(8'hB5, ACK, {tag, "_addr_r"});
   endtask

   task automatic collide(input logic [3:0] bidx, input logic [7:0] bdata,
                          input logic [3:0] hidx, input logic [7:0] hdata, input string tag);
      logic seen;
      seen = 1'b0;
      exp_wr_q.push_back(wr_t'{bidx, bdata});
      fork
         expect_ack(bdata, ACK, {tag, "_ack"});
         begin
            for (int i = 0; i < 9 * 4 * Q && !seen; i++) begin
               @(negedge clk);
               seen = bus_wr_valid;
            end
            check({tag, "_pulse_seen"}, seen, 1'b1);
            if (seen) host_write(hidx, hdata);
         end
      join
      drain_writes();
   endtask

   initial begin
      int low_before;

      repeat (4) @(negedge clk);
      check("rst_sda_t", sda_t, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_wr_valid", bus_wr_valid, 1'b0);
      check_reg(4'd0, 8'h00, "rst_reg0");
      rst = 1'b1;
      repeat (10) @(negedge clk);

      // Plain write of two bytes from pointer 3.
      i2c_start();
      check("t1_busy_after_start", busy, 1'b1);
      expect_ack(8'hB4, ACK, "t1_addr_ack");
      expect_ack(8'h03, ACK, "t1_ptr_ack");
      wr_byte(4'd3, 8'hA5, "t1_d0_ack");
      wr_byte(4'd4, 8'h3C, "t1_d1_ack");
      i2c_stop();
      repeat (10) @(negedge clk);
      check("t1_busy_after_stop", busy, 1'b0);
      check_reg(4'd3, 8'hA5, "t1_reg3");
      check_reg(4'd4, 8'h3C, "t1_reg4");

      // Repeated-start read of host-preset registers.
      host_write(4'd0, 8'h12);
      host_write(4'd1, 8'h34);
      open_read(8'h00, "t2");
      exp_rd_q.push_back(8'h12);
      read_expect(ACK, "t2_rd0");
      exp_rd_q.push_back(8'h34);
      read_expect(NACK, "t2_rd1");
      i2c_stop();

      // Foreign address: never ACKed, SDA never driven, registers untouched.
      low_before = low_cnt;
      i2c_start();
      expect_ack(8'h52, NACK, "t3_addr_nack");
      expect_ack(8'h03, NACK, "t3_ptr_nack");
      expect_ack(8'h99, NACK, "t3_data_nack");
      i2c_stop();
      check("t3_sda_released", low_cnt - low_before, 0);
      check_reg(4'd3, 8'hA5, "t3_reg3_kept");
      i2c_start();
      expect_ack(8'hB4, ACK, "t3_next_addr_ack");
      i2c_stop();

      // Pointer wrap 15 -> 0 -> 1.
      i2c_start();
      expect_ack(8'hB4, ACK, "t4_addr_ack");
      expect_ack(8'h0F, ACK, "t4_ptr_ack");
      wr_byte(4'd15, 8'h11, "t4_d0_ack");
      wr_byte(4'd0,  8'h22, "t4_d1_ack");
      wr_byte(4'd1,  8'h33, "t4_d2_ack");
      i2c_stop();
      check_reg(4'd15, 8'h11, "t4_reg15");
      check_reg(4'd0,  8'h22, "t4_reg0");
      check_reg(4'd1,  8'h33, "t4_reg1");

      // Host rewrites the register while its byte is on the wire.
      host_write(4'd6, 8'h55);
      open_read(8'h06, "t5a");
      exp_rd_q.push_back(8'h55);
      fork
         read_expect(NACK, "t5_inflight_old");
         begin
            repeat (3 * 4 * Q) @(negedge clk);
            host_write(4'd6, 8'h77);
         end
      join
      i2c_stop();
      check_reg(4'd6, 8'h77, "t5_reg6_host");
      open_read(8'h06, "t5b");
      exp_rd_q.push_back(8'h77);
      read_expect(NACK, "t5_next_new");
      i2c_stop();

      // One-clk SCL glitches, one while low and one while high.
      i2c_start();
      expect_ack(8'hB4, ACK, "t6_addr_ack");
      expect_ack(8'h08, ACK, "t6_ptr_ack");
      exp_wr_q.push_back(wr_t'{4'd8, 8'hC3});
      fork
         expect_ack(8'hC3, ACK, "t6_glitch_ack");
         begin
            repeat (2 * 4 * Q + Q / 2) @(negedge clk);
            scl_glitch = 1'b1;
            @(negedge clk);
            scl_glitch = 1'b0;
            repeat (4 * 4 * Q + 2 * Q - (2 * 4 * Q + Q / 2 + 1)) @(negedge clk);
            scl_glitch = 1'b1;
            @(negedge clk);
            scl_glitch = 1'b0;
         end
      join
      drain_writes();
      i2c_stop();
      check_reg(4'd8, 8'hC3, "t6_reg8");

      // Same-cycle host/bus writes: same index and different indices.
      i2c_start();
      expect_ack(8'hB4, ACK, "t7_addr_ack");
      expect_ack(8'h02, ACK, "t7_ptr_ack");
      collide(4'd2, 8'hBE, 4'd2, 8'h01, "t7_same");
      collide(4'd3, 8'h5D, 4'd9, 8'h99, "t7_diff");
      i2c_stop();
      check_reg(4'd2, 8'hBE, "t7_reg2_bus_wins");
      check_reg(4'd3, 8'h5D, "t7_reg3_bus");
      check_reg(4'd9, 8'h99, "t7_reg9_host");

      // Reset while the target drives a 0 data bit.
      open_read(8'h00, "t8");
      check("t8_drive_msb", sda_t, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("t8_sda_released", sda_t, 1'b1);
      check("t8_busy_cleared", busy, 1'b0);
      check_reg(4'd0,  8'h00, "t8_reg0_cleared");
      check_reg(4'd15, 8'h00, "t8_reg15_cleared");
      rst = 1'b1;
      repeat (4) @(negedge clk);
      i2c_stop();
      i2c_start();
      expect_ack(8'hB4, ACK, "t8_addr_after_reset");
      i2c_stop();

      drain_writes();
      check("wr_queue_drained", exp_wr_q.size(), 0);
      check("rd_queue_drained", exp_rd_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
